ebus_arbiter: RTL and testbench

//   Arbitrates ownership of the shared 36-bit EBUS between up to NREQ drivers.

---
 rtl/ebus_arbiter_if.sv | 13 +
 rtl/ebus_arbiter.sv | 89 ++++++++
 tb/tb_ebus_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ebus_arbiter_if.sv
// ebus_arbiter_if: request/grant bundle shared by the EBUS drivers and the arbiter
interface ebus_arbiter_if #(parameter int NREQ = 13);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] grant;
    logic [3:0]      busOwner;
    logic            busy;
    logic            xferValid;
    logic            timeout;
    logic [3:0]      errOwner;
    modport master (input req, done, output grant, busOwner, busy, xferValid, timeout, errOwner);
    modport slave (output req, done, input grant, busOwner, busy, xferValid, timeout, errOwner);
endinterface

// File: rtl/ebus_arbiter.sv
// ebus_arbiter: single-owner EBUS arbiter with priority/round-robin selection,
// setup/transfer/turnaround sequencing and hung-owner timeout
module ebus_arbiter #(
    parameter int              NREQ      = 13,
    parameter logic [NREQ-1:0] PRIO_MASK = 'h010,
    parameter int              TIMEOUT   = 255,
    parameter int              TW        = 8
) (
    input  logic           clk,
    input  logic           CROBAR_N,
    ebus_arbiter_if.master bus
);
    if (NREQ > 16) begin : g_bad_nreq
        $error("ebus_arbiter: NREQ must not exceed 16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 2**TW - 1) begin : g_bad_timeout
        $error("ebus_arbiter: TIMEOUT out of range for TW");
    end

    typedef enum logic [1:0] {IDLE, SETUP, XFER, TURN} state_t;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [NREQ-1:0] grant, prio, rot;
    logic [3:0]      owner, rr_ptr, err_owner, pwin, rwin, win, rr_n;
    logic [4:0]      roff, rsum;
    logic [TW-1:0]   cnt;
    logic            req_ow, done_ow, rel, to_hit;

    // rot[k] is req[(rr_ptr+k) mod NREQ], so its lowest set bit is the round-robin offset
    always_comb begin
        prio = bus.req & PRIO_MASK;
        rot  = NREQ'({bus.req, bus.req} >> rr_ptr);
        pwin = '0;
        roff = '0;
        for (int k = NREQ - 1; k >= 0; k--) if (prio[k]) pwin = 4'(k);
        for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) roff = 5'(k);
        rsum = {1'b0, rr_ptr} + roff;
        rwin = rsum >= 5'(NREQ) ? 4'(rsum - 5'(NREQ)) : 4'(rsum);
        win  = |prio ? pwin : rwin;
        rr_n = rwin == 4'(NREQ - 1) ? '0 : rwin + 4'd1;
    end

    // grant is one-hot on the owner while it holds the bus, so masking avoids indexing
    always_comb begin
        req_ow  = |(bus.req & grant);
        done_ow = |(bus.done & grant);
        rel     = done_ow || !req_ow;
        to_hit  = state == XFER && cnt == TLAST && !rel;
        state_n = state;
        case (state)
            IDLE:    state_n = |bus.req ? SETUP : IDLE;
            SETUP:   state_n = req_ow ? XFER : TURN;
            XFER:    state_n = rel || to_hit ? TURN : XFER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            err_owner <= '0;
        end else begin
            if (state == IDLE && |bus.req) begin
                grant <= NREQ'(1) << win;
                owner <= win;
                if (!(|prio)) rr_ptr <= rr_n;
            end
            if (state_n == TURN) grant <= '0;
            cnt <= state == XFER ? (cnt == TLAST ? cnt : cnt + 1'b1) : '0;
            if (to_hit) err_owner <= owner;
        end
    end

    assign bus.grant     = grant;
    assign bus.busOwner  = owner;
    assign bus.busy      = state != IDLE;
    assign bus.xferValid = state == XFER;
    assign bus.timeout   = to_hit;
    assign bus.errOwner  = err_owner;
endmodule

// File: tb/tb_ebus_arbiter.sv
// tb_ebus_arbiter: directed and random checks of ebus_arbiter with a grant/timeout scoreboard
module tb_ebus_arbiter;
    logic clk = 1'b0;
    logic CROBAR_N = 1'b0;
    int cmp = 0;
    int err = 0;
    bit rnd = 1'b0;
    logic [12:0] gq[$];
    int to_q[$];

    ebus_arbiter_if #(.NREQ(13)) bus ();
    ebus_arbiter_if #(.NREQ(13)) rbus ();

    ebus_arbiter #(.NREQ(13), .PRIO_MASK(13'h010), .TIMEOUT(5), .TW(8)) dut (
        .clk(clk), .CROBAR_N(CROBAR_N), .bus(bus)
    );
    ebus_arbiter #(.NREQ(13), .PRIO_MASK(13'h000), .TIMEOUT(255), .TW(8)) u_rr (
        .clk(clk), .CROBAR_N(CROBAR_N), .bus(rbus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int idx);
        int n = 0;
        while (!bus.grant[idx] && n < 40) begin
            tick();
            n++;
        end
        check("wait_grant", 32'(bus.grant[idx]), 1);
    endtask

    task automatic serve(input int idx, input int n, input bit drop);
        wait_grant(idx);
        repeat (n) tick();
        bus.done[idx] = 1'b1;
        if (drop) bus.req[idx] = 1'b0;
        tick();
        bus.done[idx] = 1'b0;
    endtask

    // monitor: pops expected owners on every new grant and expected owners on every timeout pulse
    initial begin
        logic [12:0] pg = '0;
        logic [12:0] g;
        int cyc = 0;
        int last = -100;
        int starve[13];
        foreach (starve[i]) starve[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            g = bus.grant;
            if (g != 0 && pg != 0) check("grant_hold", g, pg);
            if (g != 0 && pg == 0) begin
                check("grant_onehot", 32'($onehot(g)), 1);
                check("grant_to_grant_ge4", 32'(cyc - last >= 4), 1);
                check("busOwner", 32'(13'(1) << bus.busOwner), g);
                last = cyc;
                if (!rnd) begin
                    if (gq.size() == 0) check("grant_unexpected", g, 0);
                    else check("grant_order", g, gq.pop_front());
                end else begin
                    for (int i = 0; i < 13; i++) begin
                        if (g[i]) starve[i] = 0;
                        else if (bus.req[i]) begin
                            starve[i]++;
                            check("no_starvation", 32'(starve[i] <= 13), 1);
                        end
                    end
                end
            end
            if (rnd) for (int i = 0; i < 13; i++) if (!bus.req[i]) starve[i] = 0;
            if (bus.timeout && !rnd) begin
                if (to_q.size() == 0) check("timeout_unexpected", 1, 0);
                else check("timeout_owner", bus.busOwner, to_q.pop_front());
            end
            pg = g;
        end
    end

    initial begin
        bus.req = '0;
        bus.done = '0;
        rbus.req = '1;
        rbus.done = '0;
        // reset held with all requests raised
        repeat (3) tick();
        check("rst_grant", rbus.grant, 0);
        check("rst_busy", rbus.busy, 0);
        check("rst_timeout", rbus.timeout, 0);
        check("rst_errOwner", rbus.errOwner, 0);
        check("rst_main_grant", bus.grant, 0);
        CROBAR_N = 1'b1;
        tick();
        check("first_grant", rbus.grant, 13'h0001);
        check("first_busOwner", rbus.busOwner, 0);
        rbus.req = '0;
        repeat (3) tick();

        // round robin over 1,2,7
        gq.push_back(13'h0002); gq.push_back(13'h0004); gq.push_back(13'h0080); gq.push_back(13'h0002);
        bus.req = 13'h0086;
        serve(1, 2, 0);
        serve(2, 2, 0);
        serve(7, 2, 0);
        serve(1, 2, 0);
        bus.req = '0;
        repeat (4) tick();

        // priority: DTE beats round robin and leaves the pointer at 3
        gq.push_back(13'h0004); gq.push_back(13'h0010); gq.push_back(13'h0008); gq.push_back(13'h0020);
        bus.req = 13'h0004;
        wait_grant(2);
        tick();
        bus.req = 13'h003c;
        tick();
        bus.done[2] = 1'b1;
        bus.req[2] = 1'b0;
        tick();
        bus.done[2] = 1'b0;
        serve(4, 2, 1);
        serve(3, 2, 1);
        serve(5, 2, 1);
        repeat (4) tick();

        // timeout of owner 6, then 9 is served
        gq.push_back(13'h0040); gq.push_back(13'h0200);
        to_q.push_back(6);
        bus.req = 13'h0240;
        wait_grant(6);
        repeat (5) tick();
        check("to_pulse", bus.timeout, 1);
        check("to_xferValid", bus.xferValid, 1);
        tick();
        check("to_grant_drop", bus.grant, 0);
        check("to_errOwner", bus.errOwner, 6);
        check("to_pulse_end", bus.timeout, 0);
        check("to_turn_busy", bus.busy, 1);
        bus.req[6] = 1'b0;
        serve(9, 2, 1);
        repeat (4) tick();

        // done on the last allowed cycle wins over timeout
        gq.push_back(13'h0800);
        bus.req[11] = 1'b1;
        serve(11, 5, 1);
        check("done_vs_to_grant", bus.grant, 0);
        check("errOwner_sticky", bus.errOwner, 6);
        repeat (4) tick();

        // abort in SETUP
        gq.push_back(13'h0001);
        bus.req[0] = 1'b1;
        wait_grant(0);
        bus.req[0] = 1'b0;
        tick();
        check("abort_grant", bus.grant, 0);
        check("abort_busy", bus.busy, 1);
        check("abort_xferValid", bus.xferValid, 0);
        tick();
        check("abort_idle_busy", bus.busy, 0);
        check("abort_idle_xferValid", bus.xferValid, 0);
        repeat (3) tick();

        // done from a non-owner is ignored
        gq.push_back(13'h0008);
        bus.req[3] = 1'b1;
        wait_grant(3);
        tick();
        bus.done[8] = 1'b1;
        tick();
        bus.done[8] = 1'b0;
        check("foreign_done_grant", bus.grant, 13'h0008);
        check("foreign_done_xfer", bus.xferValid, 1);
        bus.done[3] = 1'b1;
        bus.req[3] = 1'b0;
        tick();
        bus.done[3] = 1'b0;
        check("owner_done_grant", bus.grant, 0);
        repeat (4) tick();

        // asynchronous reset mid-transfer
        gq.push_back(13'h0100);
        bus.req[8] = 1'b1;
        wait_grant(8);
        tick();
        #3;
        CROBAR_N = 1'b0;
        #1;
        check("async_rst_grant", bus.grant, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_xferValid", bus.xferValid, 0);
        check("async_rst_errOwner", bus.errOwner, 0);
        bus.req = '0;
        tick();
        CROBAR_N = 1'b1;
        repeat (2) tick();

        // random traffic; DTE stays quiet so round robin bounds every wait
        rnd = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            bus.done = '0;
            for (int i = 0; i < 13; i++) begin
                if (bus.grant[i] && bus.xferValid && $urandom_range(0, 2) == 0) begin
                    bus.done[i] = 1'b1;
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && i != 4 && $urandom_range(0, 9) == 0) bus.req[i] = 1'b1;
                else if (!bus.grant[i] && $urandom_range(0, 31) == 0) bus.done[i] = 1'b1;
            end
            tick();
        end
        bus.req = '0;
        bus.done = '0;
        repeat (20) tick();
        rnd = 1'b0;
        check("grant_queue_drained", gq.size(), 0);
        check("timeout_queue_drained", to_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
